// File: rtl/gold_count_ctrl_pkg.sv
// Shared game definitions for the gold counter: blink FSM state type and
// the default bar geometry.
package gold_count_ctrl_pkg;

  localparam int DEFAULT_MAX_GOLD     = 5;
  localparam int DEFAULT_COIN_PITCH_Y = 20;
  localparam int COUNT_W              = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } blink_state_t;

endpackage

// File: rtl/gold_slot_decode.sv
// Maps the scan pixel onto the coin bar: in-bar test, slot index and
// visibility, with registered InsideRectangle and offsets.
module gold_slot_decode
  import gold_count_ctrl_pkg::*;
#(
  parameter int MAX_GOLD     = DEFAULT_MAX_GOLD,
  parameter int COIN_PITCH_Y = DEFAULT_COIN_PITCH_Y,
  parameter int BAR_WIDTH_X  = 16,
  parameter int TOP_LEFT_X   = 600,
  parameter int TOP_LEFT_Y   = 20
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic [COUNT_W-1:0] displayCount,
  input  logic               suppress,
  output logic               InsideRectangle,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY
);

  localparam logic [10:0] X_LO = 11'(TOP_LEFT_X);
  localparam logic [10:0] X_HI = 11'(TOP_LEFT_X + BAR_WIDTH_X);
  localparam logic [10:0] Y_LO = 11'(TOP_LEFT_Y);
  localparam logic [10:0] Y_HI = 11'(TOP_LEFT_Y + MAX_GOLD * COIN_PITCH_Y);

  logic                in_bar;
  logic                visible;
  logic                hit;
  logic [10:0]         off_x;
  logic [10:0]         off_y;
  logic [MAX_GOLD-1:1] row_reached;
  logic [COUNT_W-1:0]  slot;

  assign in_bar = (pixelX >= X_LO) && (pixelX < X_HI) &&
                  (pixelY >= Y_LO) && (pixelY < Y_HI);
  assign off_x  = pixelX - X_LO;
  assign off_y  = pixelY - Y_LO;

  // Slot index is the number of slot boundaries the row has passed.
  genvar gi;
  generate
    for (gi = 1; gi < MAX_GOLD; gi++) begin : g_row
      assign row_reached[gi] = off_y >= 11'(gi * COIN_PITCH_Y);
    end
  endgenerate

  always_comb begin
    slot = '0;
    for (int i = 1; i < MAX_GOLD; i++) begin
      if (row_reached[i]) slot = slot + 3'd1;
    end
  end

  // Coins stack from the bottom: slot must reach MAX_GOLD - displayCount.
  assign visible = ({1'b0, slot} + {1'b0, displayCount}) >= 4'(MAX_GOLD);
  assign hit     = in_bar && visible && !suppress;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= hit;
      offsetX         <= hit ? off_x : 11'd0;
      offsetY         <= hit ? off_y : 11'd0;
    end
  end

endmodule

// File: rtl/gold_count_ctrl.sv
// Gold coin counter with collect/spend arbitration, a frame-synchronous
// display shadow and a blink FSM that flashes the bar after each change.
module gold_count_ctrl
  import gold_count_ctrl_pkg::*;
#(
  parameter int MAX_GOLD     = DEFAULT_MAX_GOLD,
  parameter int COIN_PITCH_Y = DEFAULT_COIN_PITCH_Y,
  parameter int BAR_WIDTH_X  = 16,
  parameter int TOP_LEFT_X   = 600,
  parameter int TOP_LEFT_Y   = 20,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_PERIOD = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               collectReq,
  input  logic               spendReq,
  input  logic [COUNT_W-1:0] spendAmount,
  output logic               spendAck,
  output logic               spendNack,
  output logic [COUNT_W-1:0] goldCount,
  output logic               goldFull,
  output logic               InsideRectangle,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY
);

  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  logic               accept;
  logic [COUNT_W-1:0] after_spend;
  logic [COUNT_W-1:0] count_next;
  logic [COUNT_W-1:0] display_count;
  blink_state_t       state;
  logic [FRAME_W-1:0] frame_cnt;
  logic [FRAME_W-1:0] half_idx;
  logic               suppress;

  // Spend is resolved first; the collect only lands if room remains.
  always_comb begin
    accept      = spendReq && (spendAmount != 3'd0) && (spendAmount <= goldCount);
    after_spend = goldCount - (accept ? spendAmount : 3'd0);
    count_next  = after_spend;
    if (collectReq && (after_spend < 3'(MAX_GOLD))) begin
      count_next = after_spend + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      goldCount     <= '0;
      display_count <= '0;
      spendAck      <= 1'b0;
      spendNack     <= 1'b0;
    end else begin
      goldCount <= count_next;
      spendAck  <= accept;
      spendNack <= spendReq && !accept;
      if (startOfFrame) display_count <= goldCount;
    end
  end

  // A count change always (re)starts the blink, even if a frame tick coincides.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else if (count_next != goldCount) begin
      state     <= BLINK;
      frame_cnt <= FRAME_W'(BLINK_FRAMES);
    end else if (state == BLINK && startOfFrame) begin
      frame_cnt <= frame_cnt - 1'b1;
      if (frame_cnt == FRAME_W'(1)) state <= IDLE;
    end
  end

  assign half_idx = frame_cnt / FRAME_W'(BLINK_PERIOD);
  assign suppress = (state == BLINK) && half_idx[0];
  assign goldFull = goldCount == 3'(MAX_GOLD);

  gold_slot_decode #(
    .MAX_GOLD    (MAX_GOLD),
    .COIN_PITCH_Y(COIN_PITCH_Y),
    .BAR_WIDTH_X (BAR_WIDTH_X),
    .TOP_LEFT_X  (TOP_LEFT_X),
    .TOP_LEFT_Y  (TOP_LEFT_Y)
  ) u_slot_decode (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .displayCount   (display_count),
    .suppress       (suppress),
    .InsideRectangle(InsideRectangle),
    .offsetX        (offsetX),
    .offsetY        (offsetY)
  );

endmodule

// File: tb/tb_gold_count_ctrl.sv
// Randomized and directed bench for gold_count_ctrl against a
// behavioural model of the coin counter, blink timing and bar display.
module tb_gold_count_ctrl;

  localparam int MAXG  = 5;
  localparam int PITCH = 20;
  localparam int BARW  = 16;
  localparam int X0    = 600;
  localparam int Y0    = 20;
  localparam int BFR   = 32;
  localparam int BPER  = 8;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        collectReq;
  logic        spendReq;
  logic [2:0]  spendAmount;
  logic        spendAck;
  logic        spendNack;
  logic [2:0]  goldCount;
  logic        goldFull;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;

  gold_count_ctrl dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .collectReq     (collectReq),
    .spendReq       (spendReq),
    .spendAmount    (spendAmount),
    .spendAck       (spendAck),
    .spendNack      (spendNack),
    .goldCount      (goldCount),
    .goldFull       (goldFull),
    .InsideRectangle(InsideRectangle),
    .offsetX        (offsetX),
    .offsetY        (offsetY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: coin total, shown total, blink frames remaining
  int m_count, m_disp, m_rem;
  bit m_blink;
  int e_ack, e_nack, e_in, e_ox, e_oy;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_count = 0; m_disp = 0; m_rem = 0; m_blink = 0;
    e_ack = 0; e_nack = 0; e_in = 0; e_ox = 0; e_oy = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, goldCount, m_count);
    check({tag, ".full"},  goldFull, (m_count == MAXG) ? 1 : 0);
    check({tag, ".ack"},   spendAck, e_ack);
    check({tag, ".nack"},  spendNack, e_nack);
    check({tag, ".in"},    InsideRectangle, e_in);
    check({tag, ".offx"},  offsetX, e_ox);
    check({tag, ".offy"},  offsetY, e_oy);
  endtask

  // One clock: predict from pre-edge model state and inputs, then compare.
  task automatic step(input string tag);
    int px, py, amt, after, nxt, slot;
    bit hidden, vis;
    px = pixelX; py = pixelY; amt = spendAmount;
    hidden = m_blink && (((m_rem / BPER) % 2) == 1);
    slot   = (py - Y0) / PITCH;
    vis = (px >= X0) && (px < X0 + BARW) && (py >= Y0) && (py < Y0 + MAXG * PITCH)
          && (slot >= MAXG - m_disp) && !hidden;
    @(posedge clk);
    e_in = vis ? 1 : 0;
    e_ox = vis ? px - X0 : 0;
    e_oy = vis ? py - Y0 : 0;
    e_ack  = (spendReq && amt >= 1 && amt <= m_count) ? 1 : 0;
    e_nack = (spendReq && e_ack == 0) ? 1 : 0;
    after = m_count - (e_ack ? amt : 0);
    nxt   = after + ((collectReq && after < MAXG) ? 1 : 0);
    if (startOfFrame) m_disp = m_count;
    if (nxt != m_count) begin
      m_blink = 1; m_rem = BFR;
    end else if (m_blink && startOfFrame) begin
      m_rem--;
      if (m_rem == 0) m_blink = 0;
    end
    m_count = nxt;
    #1;
    check_all(tag);
    collectReq = 0; spendReq = 0; startOfFrame = 0;
  endtask

  task automatic do_collect();
    collectReq = 1; step("collect");
    $display("collect -> count=%0d full=%0d", goldCount, goldFull);
  endtask

  task automatic do_spend(input int amt);
    spendReq = 1; spendAmount = 3'(amt); step("spend");
    $display("spend %0d -> ack=%0d nack=%0d count=%0d", amt, spendAck, spendNack, goldCount);
  endtask

  task automatic do_sof();
    startOfFrame = 1; step("sof");
  endtask

  initial begin
    int hidden_frames;
    resetN = 0; startOfFrame = 0; collectReq = 0; spendReq = 0; spendAmount = 0;
    pixelX = 11'd0; pixelY = 11'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    resetN = 1;

    // Fill to the cap; the sixth collect is ignored
    for (int i = 0; i < 6; i++) do_collect();
    check("fill_full", goldFull, 1);
    check("fill_cap", goldCount, 5);

    // 5 -> 3, then spend 2 from 3, then oversize and zero-amount spends
    do_spend(2);
    do_spend(2);
    check("spend2_ack", spendAck, 1);
    check("spend2_cnt", goldCount, 1);
    do_spend(4);
    check("spend4_nack", spendNack, 1);
    check("spend4_cnt", goldCount, 1);
    do_spend(0);
    check("spend0_nack", spendNack, 1);

    // Full bar: simultaneous spend 1 + collect stays at 5
    repeat (4) do_collect();
    collectReq = 1; spendReq = 1; spendAmount = 3'd1; step("both");
    $display("collect+spend 1 -> ack=%0d count=%0d", spendAck, goldCount);
    check("both_ack", spendAck, 1);
    check("both_cnt", goldCount, 5);

    // Down to 2, let the blink expire, then probe slot 2 and slot 4
    do_spend(3);
    repeat (BFR + 1) do_sof();
    pixelX = 11'd605; pixelY = 11'd75; step("pix75");
    pixelX = 11'd605; pixelY = 11'd105; step("pix105");
    $display("pixel (605,105) -> in=%0d offy=%0d", InsideRectangle, offsetY);
    check("pix105_in", InsideRectangle, 1);
    check("pix105_offy", offsetY, 85);

    // Blink timing over 40 frames with a pixel on a lit slot
    pixelX = 11'd605; pixelY = 11'd115;
    do_collect();
    hidden_frames = 0;
    for (int k = 1; k <= 40; k++) begin
      do_sof();
      step("blink");
      if (InsideRectangle == 1'b0) hidden_frames++;
    end
    $display("blink over 40 frames -> hidden=%0d", hidden_frames);
    check("blink_hidden", hidden_frames, 16);
    check("blink_idle_in", InsideRectangle, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      collectReq   = ($urandom_range(0, 3) == 0);
      spendReq     = ($urandom_range(0, 3) == 0);
      spendAmount  = 3'($urandom_range(0, 7));
      startOfFrame = ($urandom_range(0, 4) == 0);
      pixelX       = 11'($urandom_range(595, 620));
      pixelY       = 11'($urandom_range(15, 125));
      step("rand");
    end

    // Reset hits while a spend result is pending
    if (m_count == 0) do_collect();
    pixelX = 11'd0; pixelY = 11'd0;
    spendReq = 1; spendAmount = 3'd1;
    @(posedge clk);
    spendReq = 0;
    #2 resetN = 0;
    #1;
    model_reset();
    check_all("rst_pending");
    @(negedge clk);
    resetN = 1;
    repeat (3) step("post_rst");
    $display("reset during pending spend -> ack=%0d nack=%0d count=%0d", spendAck, spendNack, goldCount);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gold_count_ctrl.md
GOLD_COUNT_CTRL -- requirements
Module: gold_count_ctrl

Interface
REQ-001 SHALL have parameter MAX_GOLD, default 5: coin slots in the gold bar.
REQ-002 SHALL have parameter COIN_PITCH_Y, default 20: rows per coin slot.
REQ-003 SHALL have parameter BAR_WIDTH_X, default 16: bar width in pixels.
REQ-004 SHALL have parameter TOP_LEFT_X, default 600: bar left column.
REQ-005 SHALL have parameter TOP_LEFT_Y, default 20: bar top row.
REQ-006 SHALL have parameter BLINK_FRAMES, default 32: frames the bar blinks after a count change.
REQ-007 SHALL have parameter BLINK_PERIOD, default 8: frames per blink half-cycle.
REQ-008 SHALL have port clk, input, 1: clock.
REQ-009 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port startOfFrame, input, 1: one-cycle pulse at frame start.
REQ-011 SHALL have ports pixelX and pixelY, input, 11 each: current scan pixel.
REQ-012 SHALL have port collectReq, input, 1: add one coin (pulse).
REQ-013 SHALL have port spendReq, input, 1: spend request (pulse).
REQ-014 SHALL have port spendAmount, input, 3: coins requested, sampled with spendReq.
REQ-015 SHALL have ports spendAck and spendNack, output, 1 each: one-cycle spend result.
REQ-016 SHALL have port goldCount, output, 3: live coin count.
REQ-017 SHALL have port goldFull, output, 1: goldCount == MAX_GOLD.
REQ-018 SHALL have port InsideRectangle, output, 1: pixel lies in a visible coin slot.
REQ-019 SHALL have ports offsetX and offsetY, output, 11 each: pixel offset from the bar top-left.

Function
REQ-020 SHALL accept a spend when spendReq=1 and 1 <= spendAmount <= goldCount (pre-update count), and SHALL NACK otherwise, including spendAmount=0.
REQ-021 SHALL pulse spendAck or spendNack for exactly one cycle, in the cycle after spendReq.
REQ-022 SHALL ignore collectReq when the post-spend count equals MAX_GOLD, without any error indication.
REQ-023 SHALL, when collect and spend arrive in the same cycle, apply the spend first, then the collect: next = count - accepted_amt + (collect and (count - accepted_amt) < MAX_GOLD).
REQ-024 SHALL update goldCount one cycle after the request, never exceeding MAX_GOLD and never underflowing.
REQ-025 SHALL hold a displayCount shadow loaded from goldCount on startOfFrame only; if an update and startOfFrame occur in the same cycle, the shadow SHALL take the pre-update value.
REQ-026 SHALL implement blink FSM states IDLE and BLINK; any goldCount change SHALL enter BLINK (or stay in it) and load frameCnt = BLINK_FRAMES.
REQ-027 SHALL decrement frameCnt on each startOfFrame while in BLINK, and return to IDLE when frameCnt reaches 0.
REQ-028 SHALL suppress all slots while in BLINK when (frameCnt / BLINK_PERIOD) is odd.
REQ-029 SHALL treat a pixel as in the bar when TOP_LEFT_X <= pixelX < TOP_LEFT_X + BAR_WIDTH_X and TOP_LEFT_Y <= pixelY < TOP_LEFT_Y + MAX_GOLD*COIN_PITCH_Y.
REQ-030 SHALL compute slot = offsetY / COIN_PITCH_Y by constant comparisons (no divider); the slot SHALL be visible when slot >= MAX_GOLD - displayCount, so coins stack from the bottom.
REQ-031 SHALL register InsideRectangle, offsetX and offsetY with 1-clk latency from pixelX/pixelY; the offsets SHALL be 0 whenever InsideRectangle=0.

Reset
REQ-032 SHALL set, while resetN=0: goldCount=0, displayCount=0, FSM=IDLE, frameCnt=0, spendAck=0, spendNack=0, InsideRectangle=0, offsetX=0, offsetY=0.
REQ-033 SHALL discard any request pending at the reset assertion, producing no ack and no nack after release.

Structure
REQ-034 SHALL place the blink state enum and the MAX_GOLD/COIN_PITCH_Y defaults in the shared game package.
REQ-035 SHALL isolate the rectangle/slot decode in one sub-module, gold_slot_decode.

Verification
REQ-036 SHALL cover: reset, then 6 collectReq pulses -> goldCount goes 1..5, the 6th is ignored, goldFull=1.
REQ-037 SHALL cover: count=3, spendReq with amount=2 -> spendAck next cycle, count=1; amount=4 -> spendNack, count unchanged.
REQ-038 SHALL cover: count=5, collectReq and spendReq(amount=1) in the same cycle -> spendAck, count=5.
REQ-039 SHALL cover: count=2 with displayCount updated, pixel (605,75) -> InsideRectangle=0 (slot 2); pixel (605,105) -> InsideRectangle=1 and offsetY=85 one clk later.
REQ-040 SHALL cover: a count change followed by 40 startOfFrame pulses -> bar hidden for frames 8-15 and 24-31 of the blink, then IDLE.
REQ-041 SHALL cover: resetN pulsed low in the cycle after a spendReq -> no ack, all outputs 0.
